// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its neighbours: redirect/hazard
// controls and the ROM port in, the IF/ID pipeline register out.
interface fetch_unit_if;
    logic        stall_in;
    logic        flush_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic        jump_in;
    logic [31:0] jump_target_in;
    logic [31:0] rom_addr_out;
    logic [31:0] rom_data_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic [31:0] fetch_count_out;

    modport master (
        output stall_in, flush_in, branch_taken_in, branch_target_in,
               jump_in, jump_target_in, rom_data_in,
        input  rom_addr_out, pc_out, pc_plus4_out, instr_out, valid_out,
               fetch_count_out
    );

    modport slave (
        input  stall_in, flush_in, branch_taken_in, branch_target_in,
               jump_in, jump_target_in, rom_data_in,
        output rom_addr_out, pc_out, pc_plus4_out, instr_out, valid_out,
               fetch_count_out
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses inst_rom and loads the IF/ID
// register, honouring stall, flush and branch/jump redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  fif
);
    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_next;
    logic        w_redirect;
    logic        w_bubble;

    assign w_redirect = fif.branch_taken_in | fif.jump_in;
    // Any redirect squashes the wrong-path word currently on rom_data_in.
    assign w_bubble   = w_redirect | fif.flush_in;

    always_comb begin
        w_pc_next = r_pc + PC_STEP;
        if (fif.branch_taken_in) begin
            w_pc_next = {fif.branch_target_in[31:2], 2'b00};
        end else if (fif.jump_in) begin
            w_pc_next = {fif.jump_target_in[31:2], 2'b00};
        end else if (fif.stall_in) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_pc_out      <= 32'h0000_0000;
            r_pc_plus4    <= 32'h0000_0000;
            r_instr       <= 32'h0000_0000;
            r_valid       <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else begin
            r_pc <= w_pc_next;
            if (w_bubble) begin
                r_pc_out   <= 32'h0000_0000;
                r_pc_plus4 <= 32'h0000_0000;
                r_instr    <= 32'h0000_0000;
                r_valid    <= 1'b0;
            end else if (!fif.stall_in) begin
                r_pc_out      <= r_pc;
                r_pc_plus4    <= r_pc + 32'd4;
                r_instr       <= fif.rom_data_in;
                r_valid       <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign fif.rom_addr_out    = {2'b00, r_pc[31:2]};
    assign fif.pc_out          = r_pc_out;
    assign fif.pc_plus4_out    = r_pc_plus4;
    assign fif.instr_out       = r_instr;
    assign fif.valid_out       = r_valid;
    assign fif.fetch_count_out = r_fetch_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by random
// stimulus, predicted by a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if fif ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    // ROM contents: word k holds 32'h1000_0000 + k.
    always_comb fif.rom_data_in = 32'h1000_0000 + fif.rom_addr_out;

    typedef struct packed {
        logic [31:0] rom_addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc = 32'h0, m_pcout = 32'h0, m_pc4 = 32'h0, m_instr = 32'h0, m_count = 32'h0;
    logic        m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt,
                              input logic st, input logic fl);
        logic [31:0] word;
        exp_t e;
        word = 32'h1000_0000 + (m_pc >> 2);
        if (r) begin
            m_pc = 32'h0; m_pcout = 32'h0; m_pc4 = 32'h0;
            m_instr = 32'h0; m_valid = 1'b0; m_count = 32'h0;
        end else begin
            if (br || jp || fl) begin
                m_pcout = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            end else if (!st) begin
                m_pcout = m_pc; m_pc4 = m_pc + 32'd4; m_instr = word;
                m_valid = 1'b1; m_count = m_count + 32'd1;
            end
            if (br)      m_pc = bt & 32'hFFFF_FFFC;
            else if (jp) m_pc = jt & 32'hFFFF_FFFC;
            else if (!st) m_pc = m_pc + 32'd4;
        end
        e.rom_addr = m_pc >> 2;
        e.pc = m_pcout; e.pc4 = m_pc4; e.instr = m_instr;
        e.valid = m_valid; e.count = m_count;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs at the falling edge, then record the expectation.
    task automatic cyc(input logic r, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic st, input logic fl);
        @(negedge clk);
        rst = r;
        fif.branch_taken_in = br; fif.branch_target_in = bt;
        fif.jump_in = jp;         fif.jump_target_in = jt;
        fif.stall_in = st;        fif.flush_in = fl;
        @(posedge clk);
        model_step(r, br, bt, jp, jt, st, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents its registered state; compare to the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rom_addr", fif.rom_addr_out, e.rom_addr);
                chk("pc_out", fif.pc_out, e.pc);
                chk("pc_plus4", fif.pc_plus4_out, e.pc4);
                chk("instr", fif.instr_out, e.instr);
                chk("valid", {31'h0, fif.valid_out}, {31'h0, e.valid});
                chk("fetch_count", fif.fetch_count_out, e.count);
            end
        end
    end

    initial begin
        logic r, br, jp, st, fl;
        logic [31:0] bt, jt;
        fif.branch_taken_in = 1'b0; fif.branch_target_in = 32'h0;
        fif.jump_in = 1'b0;         fif.jump_target_in = 32'h0;
        fif.stall_in = 1'b0;        fif.flush_in = 1'b0;

        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);            // reset
        idle(2);                                                     // pc reaches 8
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);            // stall x2
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 32'h0000_0043, 1'b0, 32'h0, 1'b0, 1'b0);    // branch to 0x40
        idle(2);
        cyc(1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0080, 1'b1, 1'b0); // branch beats jump/stall
        idle(2);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);    // jump to top of memory
        idle(2);                                                     // wrap to 0
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);            // flush alone
        idle(2);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);            // flush with stall
        idle(1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);    // reset mid-redirect
        idle(3);

        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            br = ($urandom_range(0, 99) < 12);
            jp = ($urandom_range(0, 99) < 12);
            st = ($urandom_range(0, 99) < 25);
            fl = ($urandom_range(0, 99) < 10);
            bt = $urandom();
            jt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
            cyc(r, br, bt, jp, jt, st, fl);
        end
        idle(2);

        @(posedge clk);
        #4;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
